// File: rtl/pc_fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the default memory geometry, reset PC and MIPS instruction field widths.
package pc_fetch_stage_pkg;

  localparam int unsigned XLen             = 32;
  localparam int unsigned ImemBytesDefault = 56;
  localparam logic [31:0] ResetPcDefault   = 32'h0000_0000;

  localparam int unsigned OpcodeW  = 6;
  localparam int unsigned RegW     = 5;
  localparam int unsigned ImmW     = 16;
  localparam int unsigned JumpIdxW = 26;

  // Which next-state the fetch registers take this cycle.
  typedef enum logic [1:0] {
    SelSeq,
    SelStall,
    SelBranch,
    SelJump
  } pc_sel_e;

  // Word-align a redirect target and send anything outside memory back to 0.
  function automatic logic [XLen-1:0] clamp_addr(input logic [XLen-1:0] addr,
                                                 input logic [XLen-1:0] limit);
    logic [XLen-1:0] aligned;
    aligned = {addr[XLen-1:2], 2'b00};
    return (aligned >= limit) ? '0 : aligned;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: sequential increment with wrap, jump/branch
// target generation and the redirect/stall priority decision.
module next_pc_sel
  import pc_fetch_stage_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = ImemBytesDefault
) (
  input  logic [XLen-1:0]     pc_q,
  input  logic [XLen-1:0]     if_pc_plus4,
  input  logic                if_valid,
  input  logic                stall,
  input  logic                jump,
  input  logic [JumpIdxW-1:0] jump_index,
  input  logic                branch_taken,
  input  logic [ImmW-1:0]     branch_offset,
  output logic [XLen-1:0]     pc_plus4,
  output logic [XLen-1:0]     next_pc,
  output pc_sel_e             sel
);

  localparam logic [XLen-1:0] Limit = XLen'(IMEM_BYTES);

  logic [XLen-1:0] seq_pc;
  logic [XLen-1:0] br_disp;
  logic [XLen-1:0] jump_target;
  logic [XLen-1:0] branch_target;

  always_comb begin
    seq_pc   = pc_q + 32'd4;
    pc_plus4 = (seq_pc >= Limit) ? '0 : seq_pc;

    jump_target   = clamp_addr({if_pc_plus4[31:28], jump_index, 2'b00}, Limit);
    br_disp       = {{(XLen - ImmW - 2){branch_offset[ImmW-1]}}, branch_offset, 2'b00};
    branch_target = clamp_addr(if_pc_plus4 + br_disp, Limit);

    // Redirects come from the instruction in IF/ID, so only a valid one may steer.
    if (if_valid && jump) begin
      sel     = SelJump;
      next_pc = jump_target;
    end else if (if_valid && branch_taken) begin
      sel     = SelBranch;
      next_pc = branch_target;
    end else if (stall) begin
      sel     = SelStall;
      next_pc = pc_q;
    end else begin
      sel     = SelSeq;
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: program counter plus the IF/ID pipeline register.
// PC depends only on pc_q; the instruction word only ever lands in IF/ID.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = ImemBytesDefault,
  parameter logic [31:0] RESET_PC   = ResetPcDefault
) (
  input  logic                clk,
  input  logic                reset,
  output logic [31:0]         PC,
  input  logic [31:0]         Instruction_Code,
  input  logic                stall,
  input  logic                jump,
  input  logic [JumpIdxW-1:0] jump_index,
  input  logic                branch_taken,
  input  logic [ImmW-1:0]     branch_offset,
  output logic [31:0]         if_instr,
  output logic [31:0]         if_pc_plus4,
  output logic                if_valid
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  pc_sel_e     sel;

  next_pc_sel #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_next_pc_sel (
    .pc_q          (pc_q),
    .if_pc_plus4   (pc_plus4_q),
    .if_valid      (valid_q),
    .stall         (stall),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .sel           (sel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      unique case (sel)
        // Redirect flushes the wrong-path fetch but keeps IF/ID contents.
        SelJump, SelBranch: begin
          pc_q    <= next_pc;
          valid_q <= 1'b0;
        end
        SelStall: begin
          pc_q <= pc_q;
        end
        SelSeq: begin
          pc_q       <= next_pc;
          instr_q    <= Instruction_Code;
          pc_plus4_q <= pc_plus4;
          valid_q    <= 1'b1;
        end
        default: begin
          pc_q <= pc_q;
        end
      endcase
    end
  end

  assign PC          = pc_q;
  assign if_instr    = instr_q;
  assign if_pc_plus4 = pc_plus4_q;
  assign if_valid    = valid_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios plus randomized control inputs
// checked against a cycle-level behavioural model of the fetch stage.
module tb_pc_fetch_stage;

  localparam int unsigned ImemBytes = 56;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr_code;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;

  logic [31:0] imem [0:15];

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;

  always #5 clk = ~clk;

  assign instr_code = imem[pc[5:2]];

  pc_fetch_stage #(
    .IMEM_BYTES (ImemBytes),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .PC               (pc),
    .Instruction_Code (instr_code),
    .stall            (stall),
    .jump             (jump),
    .jump_index       (jump_index),
    .branch_taken     (branch_taken),
    .branch_offset    (branch_offset),
    .if_instr         (if_instr),
    .if_pc_plus4      (if_pc_plus4),
    .if_valid         (if_valid)
  );

  task automatic idle_inputs();
    stall         = 1'b0;
    jump          = 1'b0;
    jump_index    = '0;
    branch_taken  = 1'b0;
    branch_offset = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_pc(input logic [31:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (pc === want) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic run_until_pp4(input logic [31:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (if_valid === 1'b1 && if_pc_plus4 === want) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
    total++;
    if (pc !== 32'd0 || if_instr !== 32'd0 || if_pc_plus4 !== 32'd0 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold got pc=%h instr=%h pp4=%h v=%b want all zero",
               pc, if_instr, if_pc_plus4, if_valid);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (pc !== 32'd0 || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got pc=%h v=%b want pc=0 v=0", pc, if_valid);
    end
    tick();
    total++;
    if (pc !== 32'd4) begin
      bad++; $display("FAIL first_fetch_pc got=%h want=4", pc);
    end
    total++;
    if (if_instr !== 32'h0001_1020 || if_pc_plus4 !== 32'd4 || if_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_fetch_ifid got instr=%h pp4=%h v=%b want 00011020/4/1",
               if_instr, if_pc_plus4, if_valid);
    end
    tick();
    total++;
    if (pc !== 32'd8) begin
      bad++; $display("FAIL seq_pc8 got=%h want=8", pc);
    end
    tick();
    total++;
    if (pc !== 32'd12 || if_instr !== imem[2] || if_pc_plus4 !== 32'd12) begin
      bad++;
      $display("FAIL seq_pc12 got pc=%h instr=%h pp4=%h want 12/%h/12",
               pc, if_instr, if_pc_plus4, imem[2]);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    run_until_pc(32'd52, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL wrap_reach got pc=%h want=52 (timeout)", pc);
    end
    tick();
    total++;
    if (pc !== 32'd0 || if_pc_plus4 !== 32'd0 || if_valid !== 1'b1 || if_instr !== imem[13]) begin
      bad++;
      $display("FAIL wrap got pc=%h pp4=%h v=%b instr=%h want 0/0/1/%h",
               pc, if_pc_plus4, if_valid, if_instr, imem[13]);
    end
  endtask

  task automatic test_jump();
    bit ok;
    run_until_pp4(32'd24, ok);
    total++;
    if (!ok || if_instr !== 32'h0800_0006) begin
      bad++; $display("FAIL jump_setup got instr=%h want=08000006", if_instr);
    end
    jump       = 1'b1;
    jump_index = 26'd6;
    tick();
    idle_inputs();
    total++;
    if (pc !== 32'd24 || if_valid !== 1'b0 || if_instr !== 32'h0800_0006) begin
      bad++;
      $display("FAIL jump_redirect got pc=%h v=%b instr=%h want 24/0/08000006",
               pc, if_valid, if_instr);
    end
    tick();
    total++;
    if (if_instr !== 32'h17df_0001 || if_valid !== 1'b1 || pc !== 32'd28
        || if_pc_plus4 !== 32'd28) begin
      bad++;
      $display("FAIL jump_target_fetch got instr=%h v=%b pc=%h pp4=%h want 17df0001/1/28/28",
               if_instr, if_valid, pc, if_pc_plus4);
    end
  endtask

  task automatic test_branch();
    bit ok;
    run_until_pp4(32'd28, ok);
    branch_taken  = 1'b1;
    branch_offset = 16'h0001;
    tick();
    idle_inputs();
    total++;
    if (!ok || pc !== 32'd32 || if_valid !== 1'b0) begin
      bad++; $display("FAIL branch_fwd got pc=%h v=%b want 32/0", pc, if_valid);
    end
    run_until_pp4(32'd28, ok);
    branch_taken  = 1'b1;
    branch_offset = 16'hFFFF;
    tick();
    idle_inputs();
    total++;
    if (!ok || pc !== 32'd24 || if_valid !== 1'b0) begin
      bad++; $display("FAIL branch_back got pc=%h v=%b want 24/0", pc, if_valid);
    end
    // Target beyond memory falls back to 0.
    run_until_pp4(32'd28, ok);
    branch_taken  = 1'b1;
    branch_offset = 16'h0010;
    tick();
    idle_inputs();
    total++;
    if (!ok || pc !== 32'd0) begin
      bad++; $display("FAIL branch_oob got pc=%h want 0", pc);
    end
  endtask

  task automatic test_stall();
    bit ok;
    run_until_pc(32'd8, ok);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (!ok || pc !== 32'd8 || if_instr !== imem[1] || if_valid !== 1'b1
          || if_pc_plus4 !== 32'd8) begin
        bad++;
        $display("FAIL stall_hold got pc=%h instr=%h v=%b pp4=%h want 8/%h/1/8",
                 pc, if_instr, if_valid, if_pc_plus4, imem[1]);
      end
    end
    jump       = 1'b1;
    jump_index = 26'd12;
    tick();
    idle_inputs();
    total++;
    if (pc !== 32'd48 || if_valid !== 1'b0) begin
      bad++; $display("FAIL stall_jump got pc=%h v=%b want 48/0", pc, if_valid);
    end
  endtask

  task automatic test_reset_mid_jump();
    bit ok;
    run_until_pp4(32'd16, ok);
    jump       = 1'b1;
    jump_index = 26'd9;
    #2 reset = 1'b0;
    #1;
    total++;
    if (!ok || pc !== 32'd0 || if_instr !== 32'd0 || if_pc_plus4 !== 32'd0
        || if_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got pc=%h instr=%h pp4=%h v=%b want all zero",
               pc, if_instr, if_pc_plus4, if_valid);
    end
    tick();
    total++;
    if (pc !== 32'd0 || if_valid !== 1'b0) begin
      bad++; $display("FAIL reset_jump_discard got pc=%h v=%b want 0/0", pc, if_valid);
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    total++;
    if (pc !== 32'd4 || if_instr !== imem[0] || if_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_refetch got pc=%h instr=%h v=%b want 4/%h/1",
               pc, if_instr, if_valid, imem[0]);
    end
  endtask

  task automatic model_step();
    logic [31:0] t;
    int          off;
    if (m_valid && (jump || branch_taken)) begin
      if (jump) begin
        t = {m_pp4[31:28], jump_index, 2'b00};
      end else begin
        off = int'($signed(branch_offset));
        t   = m_pp4 + 32'(off * 4);
      end
      if (t >= ImemBytes) t = 32'd0;
      m_pc    = t;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = imem[m_pc / 4];
      t       = m_pc + 32'd4;
      if (t >= ImemBytes) t = 32'd0;
      m_pc    = t;
      m_pp4   = t;
      m_valid = 1'b1;
    end
  endtask

  task automatic test_random();
    reset = 1'b0;
    idle_inputs();
    tick();
    #2 reset = 1'b1;
    m_pc = 32'd0; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      stall         = ($urandom_range(0, 99) < 30);
      jump          = ($urandom_range(0, 99) < 12);
      branch_taken  = ($urandom_range(0, 99) < 18);
      jump_index    = ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'($urandom_range(0, 16));
      branch_offset = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                  : 16'($urandom_range(0, 24) - 12);
      model_step();
      tick();
      total++;
      if (pc !== m_pc) begin
        bad++; $display("FAIL rnd_pc cycle=%0d got=%h want=%h", c, pc, m_pc);
      end
      total++;
      if (if_valid !== m_valid) begin
        bad++; $display("FAIL rnd_valid cycle=%0d got=%b want=%b", c, if_valid, m_valid);
      end
      total++;
      if (if_instr !== m_instr) begin
        bad++; $display("FAIL rnd_instr cycle=%0d got=%h want=%h", c, if_instr, m_instr);
      end
      total++;
      if (if_pc_plus4 !== m_pp4) begin
        bad++; $display("FAIL rnd_pp4 cycle=%0d got=%h want=%h", c, if_pc_plus4, m_pp4);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 32'hA500_0000 + 32'(i * 32'h0101);
    imem[0] = 32'h0001_1020;
    imem[5] = 32'h0800_0006;
    imem[6] = 32'h17df_0001;
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_wrap();
    test_jump();
    test_branch();
    test_stall();
    test_reset_mid_jump();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter IMEM_BYTES, default 56, size of instruction memory in bytes (multiple of 4, at least 8).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset (word-aligned).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset==0 clears state immediately.
REQ-005 PC  output  32  byte address driven to instruction memory; equals pc_q.
REQ-006 Instruction_Code  input  32  word returned combinationally by instruction memory for PC.
REQ-007 stall  input  1  hold PC and IF/ID register this cycle.
REQ-008 jump  input  1  J/JAL redirect, decoded from if_instr.
REQ-009 jump_index  input  26  jump word index, i.e. if_instr[25:0].
REQ-010 branch_taken  input  1  BEQ/BNE condition true for if_instr.
REQ-011 branch_offset  input  16  signed word offset, i.e. if_instr[15:0].
REQ-012 if_instr  output  32  registered instruction (IF/ID).
REQ-013 if_pc_plus4  output  32  registered PC+4 of if_instr; also JAL link value.
REQ-014 if_valid  output  1  if_instr holds a real fetched instruction.

Function
REQ-015 pc_plus4 SHALL equal pc_q+4, except it SHALL equal 0 when pc_q+4 >= IMEM_BYTES (wrap).
REQ-016 jump target SHALL be {if_pc_plus4[31:28], jump_index, 2'b00}.
REQ-017 branch target SHALL be if_pc_plus4 + (sign-extended branch_offset << 2), modulo 2^32.
REQ-018 Redirect targets SHALL have bits [1:0] forced to 0; targets >= IMEM_BYTES SHALL load 0.
REQ-019 jump and branch_taken SHALL be honoured only when if_valid==1.
REQ-020 Next-state priority: reset > jump > branch_taken > stall > sequential.
REQ-021 Jump or taken branch: pc_q <= target; if_valid <= 0 (flush wrong-path fetch); if_instr/if_pc_plus4 hold.
REQ-022 Redirect SHALL override stall in the same cycle.
REQ-023 Stall without redirect: pc_q, if_instr, if_pc_plus4, if_valid all hold.
REQ-024 Sequential: pc_q <= pc_plus4; if_instr <= Instruction_Code; if_pc_plus4 <= pc_plus4; if_valid <= 1.
REQ-025 Fetch-to-IF/ID latency SHALL be exactly one cycle; redirect penalty exactly one bubble.
REQ-026 PC SHALL be combinational from pc_q only (no path from Instruction_Code to PC).
REQ-027 jump and branch_taken both asserted: jump wins, branch ignored.

Reset
REQ-028 While reset==0: pc_q=RESET_PC, if_instr=0, if_pc_plus4=0, if_valid=0, asynchronously.
REQ-029 First rising edge after reset deasserts SHALL perform a sequential fetch of RESET_PC.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard the pending update.

Structure
REQ-031 Shared package holds IMEM_BYTES default, RESET_PC default, and the instruction field widths (6/5/16/26).
REQ-032 One sub-module, next_pc_sel, SHALL hold combinational pc_plus4/target/wrap/priority logic; registers stay in pc_fetch_stage.

Verification
REQ-033 Hold reset=0 3 cycles, release -> PC=0, if_valid=0; next edges PC=4,8,12; if_instr=32'h00011020 after first edge.
REQ-034 Run to pc_q=52 -> next PC=0 (wrap), if_pc_plus4=0, if_valid=1.
REQ-035 if_instr=32'h08000006 valid, jump=1, jump_index=6 -> PC=24 next cycle, if_valid=0 one cycle, then if_instr=32'h17df0001.
REQ-036 if_pc_plus4=28, branch_taken=1, offset=16'h0001 -> PC=32; offset=16'hFFFF -> PC=24.
REQ-037 stall=1 for 2 cycles at PC=8 -> PC, if_instr, if_valid unchanged; stall plus jump same cycle -> jump taken.
REQ-038 reset=0 asserted between edges during jump -> outputs reach reset values before next edge; jump discarded.
